// File: rtl/bus_arb4.sv
// Four-requester arbiter for the shared 8-bit data bus: bounded-tenure round-robin grant plus registered byte stage.
// Define ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module bus_arb4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    input  logic [3:0] lock,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [7:0] in3,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic [7:0] bus_out,
    output logic       bus_valid,
    output logic [1:0] bus_src
);

    typedef enum logic {IDLE, OWN} state_t;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t     r_state, w_nextState;
    logic [3:0] r_gnt, w_nextGnt;
    logic [1:0] r_sel, w_nextSel;
    logic [1:0] r_ptr, w_nextPtr;
    logic [3:0] r_holdCnt, w_nextHold;
    logic [7:0] r_busOut;
    logic       r_busValid;
    logic [1:0] r_busSrc;

    logic [3:0] w_ownerHot;
    logic       w_normalRel;
    logic       w_forcedRel;
    logic       w_arbitrate;
    logic [3:0] w_cand;
    logic [1:0] w_basePtr;
    logic       w_found;
    logic [1:0] w_winner;
    logic [7:0] w_selByte;

    assign w_ownerHot  = 4'b0001 << r_sel;
    assign w_normalRel = !req[r_sel] || !lock[r_sel];
    assign w_forcedRel = !w_normalRel && (r_holdCnt == HOLD_LAST) && ((req & ~w_ownerHot) != 4'b0000);
    assign w_arbitrate = (r_state == IDLE) || w_normalRel || w_forcedRel;
    assign w_cand      = w_forcedRel ? (req & ~w_ownerHot) : req;

    // Fixed priority is round-robin with the pointer pinned at 3, so requester 0 is always searched first.
`ifdef ARB_FIXED_PRIO_EN
    assign w_basePtr = 2'd3;
`else
    assign w_basePtr = r_ptr;
`endif

    always_comb begin
        w_found  = 1'b0;
        w_winner = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            if (w_cand[w_basePtr + 2'(i)]) begin
                w_found  = 1'b1;
                w_winner = w_basePtr + 2'(i);
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextGnt   = r_gnt;
        w_nextSel   = r_sel;
        w_nextPtr   = r_ptr;
        w_nextHold  = r_holdCnt;
        if (w_arbitrate) begin
            w_nextHold = 4'd0;
            if (w_found) begin
                w_nextState = OWN;
                w_nextGnt   = 4'b0001 << w_winner;
                w_nextSel   = w_winner;
                w_nextPtr   = w_winner;
            end else begin
                w_nextState = IDLE;
                w_nextGnt   = 4'b0000;
            end
        end else if (r_holdCnt != HOLD_LAST) begin
            w_nextHold = r_holdCnt + 4'd1;
        end
    end

    always_comb begin
        case (r_sel)
            2'd0:    w_selByte = in0;
            2'd1:    w_selByte = in1;
            2'd2:    w_selByte = in2;
            default: w_selByte = in3;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_gnt      <= 4'b0000;
            r_sel      <= 2'd0;
            r_ptr      <= 2'd3;
            r_holdCnt  <= 4'd0;
            r_busOut   <= 8'h00;
            r_busValid <= 1'b0;
            r_busSrc   <= 2'd0;
        end else begin
            r_state    <= w_nextState;
            r_gnt      <= w_nextGnt;
            r_sel      <= w_nextSel;
            r_ptr      <= w_nextPtr;
            r_holdCnt  <= w_nextHold;
            r_busValid <= (r_gnt != 4'b0000);
            if (r_gnt != 4'b0000) begin
                r_busOut <= w_selByte;
                r_busSrc <= r_sel;
            end
        end
    end

    always_comb begin
        gnt       = r_gnt;
        sel       = r_sel;
        bus_out   = r_busOut;
        bus_valid = r_busValid;
        bus_src   = r_busSrc;
    end

endmodule

// File: tb/tb_bus_arb4.sv
// Directed bench for bus_arb4: grant sequence checked per cycle, bus bytes checked by a queue-based monitor.
module tb_bus_arb4;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] src;
    } expItem_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] lock;
    logic [7:0] in0, in1, in2, in3;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [7:0] bus_out;
    logic       bus_valid;
    logic [1:0] bus_src;

    expItem_t   expQ[$];
    int         nVectors = 0;
    int         nMiscompares = 0;
    logic [1:0] expSel;
    logic [7:0] inTable[4];

    bus_arb4 #(.MAX_HOLD(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .lock      (lock),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .gnt       (gnt),
        .sel       (sel),
        .bus_out   (bus_out),
        .bus_valid (bus_valid),
        .bus_src   (bus_src)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l);
        req  = r;
        lock = l;
        @(posedge clk);
        #1;
    endtask

    // Expected grant is hand-computed by the caller; a granted cycle queues the byte expected one edge later.
    task automatic checkOutput(input logic [3:0] expGnt, input string name);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) if (expGnt[i]) idx = 2'(i);
        if (expGnt != 4'b0000) expSel = idx;
        nVectors++;
        if (gnt !== expGnt || sel !== expSel) begin
            nMiscompares++;
            $display("[TB] FAIL %s: gnt=%b sel=%0d, expected gnt=%b sel=%0d", name, gnt, sel, expGnt, expSel);
        end
        if (expGnt != 4'b0000) expQ.push_back({inTable[idx], idx});
    endtask

    task automatic checkValue(input string name, input logic [7:0] act, input logic [7:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] l, input logic [3:0] expGnt, input string name);
        applyStimulus(r, l);
        checkOutput(expGnt, name);
    endtask

    always @(negedge clk) begin
        expItem_t e;
        if (reset_n === 1'b1 && bus_valid === 1'b1) begin
            nVectors++;
            if (expQ.size() == 0) begin
                nMiscompares++;
                $display("[TB] FAIL bus_unexpected: bus_out=%h bus_src=%0d with nothing expected", bus_out, bus_src);
            end else begin
                e = expQ.pop_front();
                if (bus_out !== e.data || bus_src !== e.src) begin
                    nMiscompares++;
                    $display("[TB] FAIL bus_data: bus_out=%h bus_src=%0d, expected %h src %0d",
                             bus_out, bus_src, e.data, e.src);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        inTable[0] = 8'hA5;
        inTable[1] = 8'h3C;
        inTable[2] = 8'h5A;
        inTable[3] = 8'hC3;
        in0 = inTable[0];
        in1 = inTable[1];
        in2 = inTable[2];
        in3 = inTable[3];
        req = 4'b0000;
        lock = 4'b0000;
        expSel = 2'd0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        checkValue("reset_gnt", {4'b0, gnt}, 8'h00);
        checkValue("reset_sel", {6'b0, sel}, 8'h00);
        checkValue("reset_bus_out", bus_out, 8'h00);
        checkValue("reset_bus_valid", {7'b0, bus_valid}, 8'h00);
        checkValue("reset_bus_src", {6'b0, bus_src}, 8'h00);

        // Single requester, back-to-back re-grant, then idle.
        step(4'b0001, 4'b0000, 4'b0001, "single_grant");
        step(4'b0001, 4'b0000, 4'b0001, "regrant_same_owner");
        step(4'b0000, 4'b0000, 4'b0000, "idle_after_release");

        // All requesting, unlocked: rotation continues from last owner 0.
        step(4'b1111, 4'b0000, 4'b0010, "rr_1");
        step(4'b1111, 4'b0000, 4'b0100, "rr_2");
        step(4'b1111, 4'b0000, 4'b1000, "rr_3");
        step(4'b1111, 4'b0000, 4'b0001, "rr_0");
        step(4'b1111, 4'b0000, 4'b0010, "rr_1_again");

        // Owner 2 locked with requester 1 pending: exactly 8 cycles, then 1.
        for (int i = 0; i < 8; i++) step(4'b0110, 4'b0100, 4'b0100, $sformatf("locked_hold_%0d", i));
        step(4'b0110, 4'b0100, 4'b0010, "forced_release_to_1");
        step(4'b0000, 4'b0000, 4'b0000, "idle_after_forced");

        // Owner 2 locked alone: tenure never ends until someone else asks.
        step(4'b0100, 4'b0100, 4'b0100, "lock_alone_grant");
        for (int i = 0; i < 12; i++) step(4'b0100, 4'b0100, 4'b0100, $sformatf("lock_alone_%0d", i));
        step(4'b0101, 4'b0100, 4'b0001, "saturated_release_to_0");

        // Asynchronous reset during a locked tenure of requester 0.
        step(4'b0001, 4'b0001, 4'b0001, "pre_reset_tenure");
        #2;
        reset_n = 1'b0;
        #1;
        checkValue("async_gnt", {4'b0, gnt}, 8'h00);
        checkValue("async_bus_valid", {7'b0, bus_valid}, 8'h00);
        checkValue("async_bus_out", bus_out, 8'h00);
        expQ.delete();
        expSel = 2'd0;
        #4;
        reset_n = 1'b1;
        step(4'b1010, 4'b0000, 4'b0010, "post_reset_first_win");
        step(4'b0000, 4'b0000, 4'b0000, "post_reset_idle");
        step(4'b0000, 4'b0000, 4'b0000, "drain");

        nVectors++;
        if (expQ.size() != 0) begin
            nMiscompares++;
            $display("[TB] FAIL bus_missing: %0d expected bytes never presented, expected 0", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
